gold_corr: RTL and testbench
============================

GOLD_CORR -- requirements
Module: gold_corr

Interface
REQ-001 Parameter N, default 63: Gold code length in chips.
REQ-002 Parameter LENGTH, default $clog2(N) (6): polynomial degree and code2 width.
REQ-003 Parameter THRESH, default 48: correlation peak threshold, signed.
REQ-004 Port clkin, input, 1: sole clock, rising edge.
REQ-005 Port rstn, input, 1: reset, asynchronous, active-low.
REQ-006 Port code2_i, input, LENGTH: seed for the second LFSR.
REQ-007 Port tvalid_i, input, 1: code2_i valid.
REQ-008 Port ready_o, output, 1: block can accept a seed.
REQ-009 Port chip_i, input, 1: received serial chip.
REQ-010 Port chip_valid_i, input, 1: chip_i valid this cycle.
REQ-011 Port corr_o, output, LENGTH+2 signed: window correlation, range -N..+N.
REQ-012 Port corr_valid_o, output, 1: corr_o valid, one-cycle pulse.
REQ-013 Port peak_o, output, 1: corr_o >= THRESH, qualified by corr_valid_o.
REQ-014 Port phase_o, output, LENGTH: chip index mod N of the last peak.
REQ-015 Port lock_o, output, 1: code phase acquired.

Function
REQ-016 FSM states are IDLE, GEN, SEARCH and LOCKED.
REQ-017 Seed handshake: transfer when tvalid_i && ready_o; ready_o=1 in IDLE, SEARCH and LOCKED; ready_o=0 in GEN.
REQ-018 On transfer, from any state: go to GEN; clear window, chip counter, lock, peak history; load LFSR1=all-ones, LFSR2=code2_i.
REQ-019 If code2_i==0, load LFSR2 with 1 instead (all-zero state forbidden).
REQ-020 LFSR1 uses x^6+x+1; LFSR2 uses x^6+x^5+x^2+x+1; ref chip = MSB(LFSR1) XOR MSB(LFSR2).
REQ-021 GEN: shift one ref chip per cycle into an N-bit reference register for exactly N cycles, then go to SEARCH.
REQ-022 Chips arriving during IDLE or GEN are dropped; no corr_valid_o is produced for them.
REQ-023 SEARCH/LOCKED: each valid chip shifts into an N-bit window (newest at bit 0) and advances chip counter 0..N-1, wrapping N-1->0.
REQ-024 corr = N - 2*popcount(window XOR ref), where chip 1 maps to +1.
REQ-025 Latency: corr_o and corr_valid_o appear 2 cycles after the accepting chip edge (XOR/popcount stage, then scale stage); one result per valid chip; back-to-back chips are supported.
REQ-026 corr_o holds its last value while corr_valid_o=0.
REQ-027 A peak latches phase_o with the chip counter of that chip.
REQ-028 SEARCH->LOCKED: two peaks exactly N valid chips apart.
REQ-029 LOCKED: the expected peak position is phase_o + N chips.
REQ-030 LOCKED->SEARCH: two consecutive expected positions without a peak; a single miss keeps lock.
REQ-031 A peak at a non-expected position while LOCKED is ignored; phase_o is unchanged.
REQ-032 Peak evaluation is skipped until N chips have filled the window after GEN; corr_valid_o still pulses.
REQ-033 A seed transfer on the same cycle as a valid chip: the transfer wins and the chip is dropped.

Reset
REQ-034 While rstn=0: state=IDLE, ready_o=1, corr_o=0, corr_valid_o=0, peak_o=0, phase_o=0, lock_o=0; registers cleared.
REQ-035 Reset deassertion mid-GEN or mid-LOCKED restarts in IDLE; a new seed is required before correlation.

Structure
REQ-036 Package gold_pkg holds N, LENGTH, both tap masks and the FSM state enum, shared with the Gold generator.
REQ-037 Sub-module gold_lfsr (Fibonacci, parameterised taps, load/enable) is instantiated twice.

Verification
REQ-038 Seed 6'h15; feed the matching Gold stream aligned; first full window -> corr_o=+63, peak_o=1; second peak 63 chips later -> lock_o=1.
REQ-039 Same stream inverted -> corr_o=-63 every period, peak_o=0, lock_o stays 0.
REQ-040 Locked, then 2 whole periods of the wrong seed's code -> lock_o falls after the second missed expected peak; a single missed period keeps lock_o=1.
REQ-041 code2_i=0 with tvalid_i=1 -> ready_o=0 for 63 cycles, then the reference equals the seed-1 sequence.
REQ-042 Seed transfer and chip_valid_i on the same cycle while LOCKED -> lock_o=0 next cycle, no corr_valid_o for that chip.
REQ-043 rstn pulsed low mid-GEN -> all outputs at reset values; ready_o=1; no corr_valid_o until a reseed and N cycles.

Source files
------------

// File: rtl/gold_pkg.sv
// Shared constants for the Gold code correlator: code length, LFSR degree,
// feedback tap masks and the controller state encoding.
package gold_pkg;

    localparam int GOLD_N      = 63;
    localparam int GOLD_LENGTH = 6;

    // Tap masks: bit k set means stage k joins the feedback XOR.
    // Stage 5 is the MSB, which is the chip output.
    localparam logic [GOLD_LENGTH-1:0] GOLD_TAPS1 = 6'b100001;  // x^6+x+1
    localparam logic [GOLD_LENGTH-1:0] GOLD_TAPS2 = 6'b110011;  // x^6+x^5+x^2+x+1

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GEN    = 2'd1,
        SEARCH = 2'd2,
        LOCKED = 2'd3
    } state_t;

endpackage

// File: rtl/gold_lfsr.sv
// Fibonacci LFSR with a parameterised tap mask; shifts toward the MSB,
// which is the output chip.
module gold_lfsr #(
    parameter int           W    = 6,
    parameter logic [W-1:0] TAPS = '1
) (
    input  logic         clkin,
    input  logic         rstn,
    input  logic         load,
    input  logic [W-1:0] seed,
    input  logic         enable,
    output logic         msb
);

    logic [W-1:0] sr;

    always_ff @(posedge clkin or negedge rstn) begin
        if (!rstn) begin
            sr <= '0;
        end else if (load) begin
            sr <= seed;
        end else if (enable) begin
            sr <= {sr[W-2:0], ^(sr & TAPS)};
        end
    end

    assign msb = sr[W-1];

endmodule

// File: rtl/gold_corr.sv
// Gold code correlator: builds an N-chip reference from a seeded generator,
// slides received chips past it and tracks the code phase of correlation peaks.
//
//   state  | meaning
//   IDLE   | waiting for the first seed, chips dropped
//   GEN    | shifting N reference chips out of the generator, chips dropped
//   SEARCH | correlating, looking for two peaks exactly N chips apart
//   LOCKED | phase acquired, expecting a peak every N chips
module gold_corr
    import gold_pkg::*;
#(
    parameter int N      = GOLD_N,
    parameter int LENGTH = $clog2(N),
    parameter int THRESH = 48
) (
    input  logic                     clkin,
    input  logic                     rstn,
    input  logic [LENGTH-1:0]        code2_i,
    input  logic                     tvalid_i,
    output logic                     ready_o,
    input  logic                     chip_i,
    input  logic                     chip_valid_i,
    output logic signed [LENGTH+1:0] corr_o,
    output logic                     corr_valid_o,
    output logic                     peak_o,
    output logic [LENGTH-1:0]        phase_o,
    output logic                     lock_o
);

    localparam int                CW   = LENGTH + 2;
    localparam logic [LENGTH-1:0] LAST = LENGTH'(N - 1);
    localparam logic [LENGTH-1:0] ONE  = LENGTH'(1);

    state_t              state, state_nx;
    logic                xfer, accept, gen_en, msb1, msb2;
    logic [LENGTH-1:0]   seed2, gen_cnt, fill_cnt, chip_cnt, dist_cnt;
    logic [N-1:0]        ref_sr, win;
    logic [LENGTH:0]     pop_nx, s1_pop;
    logic                p0_valid, p0_eval, s1_valid, s1_eval;
    logic [LENGTH-1:0]   p0_idx, s1_idx;
    logic                hist_valid, miss;
    logic signed [CW-1:0] corr_nx;
    logic                hit, expected, lock_evt, unlock_evt;

    assign xfer   = tvalid_i && ready_o;
    assign accept = chip_valid_i && !xfer && (state == SEARCH || state == LOCKED);
    assign gen_en = (state == GEN);
    assign seed2  = (code2_i == '0) ? ONE : code2_i;

    gold_lfsr #(.W(LENGTH), .TAPS(GOLD_TAPS1)) u_lfsr1 (
        .clkin  (clkin),
        .rstn   (rstn),
        .load   (xfer),
        .seed   ({LENGTH{1'b1}}),
        .enable (gen_en),
        .msb    (msb1)
    );

    gold_lfsr #(.W(LENGTH), .TAPS(GOLD_TAPS2)) u_lfsr2 (
        .clkin  (clkin),
        .rstn   (rstn),
        .load   (xfer),
        .seed   (seed2),
        .enable (gen_en),
        .msb    (msb2)
    );

    // Reference generation, chip window and the counters that follow them.
    always_ff @(posedge clkin or negedge rstn) begin
        if (!rstn) begin
            gen_cnt  <= '0;
            fill_cnt <= '0;
            chip_cnt <= '0;
            ref_sr   <= '0;
            win      <= '0;
            p0_valid <= 1'b0;
            p0_eval  <= 1'b0;
            p0_idx   <= '0;
        end else if (xfer) begin
            gen_cnt  <= LAST;
            fill_cnt <= LAST;
            chip_cnt <= '0;
            ref_sr   <= '0;
            win      <= '0;
            p0_valid <= 1'b0;
            p0_eval  <= 1'b0;
        end else begin
            p0_valid <= accept;
            if (gen_en) begin
                ref_sr <= {ref_sr[N-2:0], msb1 ^ msb2};
                if (gen_cnt != '0) gen_cnt <= gen_cnt - ONE;
            end
            if (accept) begin
                win      <= {win[N-2:0], chip_i};
                p0_eval  <= (fill_cnt == '0);
                p0_idx   <= chip_cnt;
                chip_cnt <= (chip_cnt == LAST) ? '0 : chip_cnt + ONE;
                if (fill_cnt != '0) fill_cnt <= fill_cnt - ONE;
            end
        end
    end

    always_comb begin
        pop_nx = '0;
        for (int i = 0; i < N; i++) begin
            pop_nx = pop_nx + {{LENGTH{1'b0}}, win[i] ^ ref_sr[i]};
        end
    end

    always_ff @(posedge clkin or negedge rstn) begin
        if (!rstn) begin
            s1_valid <= 1'b0;
            s1_eval  <= 1'b0;
            s1_idx   <= '0;
            s1_pop   <= '0;
        end else begin
            s1_valid <= p0_valid && !xfer;
            s1_eval  <= p0_eval;
            s1_idx   <= p0_idx;
            s1_pop   <= pop_nx;
        end
    end

    // dist_cnt reaches zero on the result that sits N chips after the last peak.
    always_comb begin
        corr_nx    = $signed(CW'(N)) - $signed({s1_pop, 1'b0});
        hit        = s1_valid && s1_eval && (corr_nx >= $signed(CW'(THRESH)));
        expected   = s1_valid && s1_eval && hist_valid && (dist_cnt == '0);
        lock_evt   = (state == SEARCH) && expected && hit;
        unlock_evt = (state == LOCKED) && expected && !hit && miss;
    end

    always_ff @(posedge clkin or negedge rstn) begin
        if (!rstn) begin
            corr_o       <= '0;
            corr_valid_o <= 1'b0;
            peak_o       <= 1'b0;
            phase_o      <= '0;
            hist_valid   <= 1'b0;
            dist_cnt     <= '0;
            miss         <= 1'b0;
        end else if (xfer) begin
            corr_valid_o <= 1'b0;
            peak_o       <= 1'b0;
            hist_valid   <= 1'b0;
            dist_cnt     <= '0;
            miss         <= 1'b0;
        end else begin
            corr_valid_o <= s1_valid;
            peak_o       <= hit;
            if (s1_valid) corr_o <= corr_nx;
            if (s1_valid && s1_eval) begin
                if (state == LOCKED) begin
                    if (expected) begin
                        dist_cnt <= LAST;
                        miss     <= !hit && !miss;
                        if (hit) phase_o <= s1_idx;
                        if (unlock_evt) hist_valid <= 1'b0;
                    end else if (dist_cnt != '0) begin
                        dist_cnt <= dist_cnt - ONE;
                    end
                end else begin
                    if (hit) begin
                        phase_o    <= s1_idx;
                        hist_valid <= 1'b1;
                        dist_cnt   <= LAST;
                        miss       <= 1'b0;
                    end else if (expected) begin
                        hist_valid <= 1'b0;
                    end else if (dist_cnt != '0) begin
                        dist_cnt <= dist_cnt - ONE;
                    end
                end
            end
        end
    end

    always_ff @(posedge clkin or negedge rstn) begin
        if (!rstn) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        if (xfer) begin
            state_nx = GEN;
        end else begin
            case (state)
                IDLE:    state_nx = IDLE;
                GEN:     if (gen_cnt == '0) state_nx = SEARCH;
                SEARCH:  if (lock_evt) state_nx = LOCKED;
                LOCKED:  if (unlock_evt) state_nx = SEARCH;
                default: state_nx = IDLE;
            endcase
        end
    end

    always_comb begin
        ready_o = (state != GEN);
        lock_o  = (state == LOCKED);
    end

endmodule

// File: tb/tb_gold_corr.sv
// Directed bench for gold_corr: alignment peaks, inversion, lock/unlock,
// zero seed, seed/chip collision and reset during generation.
module tb_gold_corr;

    localparam int N = 63;
    localparam int L = 6;

    logic                clkin = 1'b0;
    logic                rstn  = 1'b0;
    logic [L-1:0]        code2 = '0;
    logic                tvalid = 1'b0;
    logic                ready;
    logic                chip = 1'b0;
    logic                chip_valid = 1'b0;
    logic signed [L+1:0] corr;
    logic                corr_valid, peak, lock;
    logic [L-1:0]        phase;

    int checks = 0;
    int failures = 0;
    int nres, npk, nneg, last_corr;
    logic [N-1:0] seq_a, seq_b, seq_c;

    always #5 clkin = ~clkin;

    gold_corr dut (
        .clkin        (clkin),
        .rstn         (rstn),
        .code2_i      (code2),
        .tvalid_i     (tvalid),
        .ready_o      (ready),
        .chip_i       (chip),
        .chip_valid_i (chip_valid),
        .corr_o       (corr),
        .corr_valid_o (corr_valid),
        .peak_o       (peak),
        .phase_o      (phase),
        .lock_o       (lock)
    );

    // Chip k of the Gold code for a seed: LFSR1 from all-ones, LFSR2 from the seed.
    function automatic logic [N-1:0] gold_seq(input logic [5:0] seed);
        logic [5:0]   a, b;
        logic [N-1:0] s;
        a = 6'h3F;
        b = (seed == 6'h00) ? 6'h01 : seed;
        s = '0;
        for (int k = 0; k < N; k++) begin
            s[k] = a[5] ^ b[5];
            a = {a[4:0], a[5] ^ a[0]};
            b = {b[4:0], b[5] ^ b[4] ^ b[1] ^ b[0]};
        end
        return s;
    endfunction

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clkin);
        #1;
        if (corr_valid) begin
            nres++;
            last_corr = int'(corr);
            if (peak) npk++;
            if (int'(corr) == -N) nneg++;
        end
    endtask

    task automatic clr();
        nres = 0;
        npk = 0;
        nneg = 0;
        last_corr = 0;
    endtask

    task automatic feed(input logic [N-1:0] s, input int first, input int count, input logic inv);
        for (int k = first; k < first + count; k++) begin
            chip = s[k % N] ^ inv;
            chip_valid = 1'b1;
            cycle();
        end
        chip_valid = 1'b0;
    endtask

    task automatic drain();
        repeat (3) cycle();
    endtask

    task automatic load_seed(input logic [5:0] s, input logic gen_chips, output int low);
        code2 = s;
        tvalid = 1'b1;
        chip = 1'b1;
        chip_valid = gen_chips;
        cycle();
        tvalid = 1'b0;
        low = 0;
        while (!ready && low < 200) begin
            low++;
            cycle();
        end
        chip_valid = 1'b0;
    endtask

    task automatic wait_ready();
        int n;
        n = 0;
        while (!ready && n < 200) begin
            n++;
            cycle();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time exhausted");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        int low;
        seq_a = gold_seq(6'h15);
        seq_b = gold_seq(6'h2A);
        seq_c = gold_seq(6'h01);
        clr();

        repeat (3) cycle();
        chk("rst_ready", ready, 1);
        chk("rst_corr", int'(corr), 0);
        chk("rst_valid", corr_valid, 0);
        chk("rst_peak", peak, 0);
        chk("rst_phase", phase, 0);
        chk("rst_lock", lock, 0);
        rstn = 1'b1;
        cycle();

        clr();
        feed(seq_a, 0, 8, 1'b0);
        drain();
        chk("idle_drop", nres, 0);

        clr();
        load_seed(6'h15, 1'b1, low);
        chk("gen_ready_low", low, 63);
        chk("gen_drop", nres, 0);

        chip = seq_a[0];
        chip_valid = 1'b1;
        cycle();
        chip_valid = 1'b0;
        chk("lat_e0", corr_valid, 0);
        cycle();
        chk("lat_e1", corr_valid, 0);
        cycle();
        chk("lat_e2", corr_valid, 1);

        feed(seq_a, 1, 62, 1'b0);
        drain();
        chk("p1_results", nres, 63);
        chk("p1_corr", last_corr, 63);
        chk("p1_peaks", npk, 1);
        chk("p1_phase", phase, 62);
        chk("p1_lock", lock, 0);

        clr();
        feed(seq_a, 0, 63, 1'b0);
        drain();
        chk("p2_results", nres, 63);
        chk("p2_peaks", npk, 1);
        chk("p2_corr", last_corr, 63);
        chk("p2_lock", lock, 1);

        // one wrong period keeps lock, a good period re-arms it
        clr();
        feed(seq_b, 0, 63, 1'b0);
        drain();
        chk("miss1_lock", lock, 1);
        chk("miss1_peaks", npk, 0);
        feed(seq_a, 0, 63, 1'b0);
        drain();
        chk("recover_corr", last_corr, 63);
        chk("recover_lock", lock, 1);
        feed(seq_b, 0, 63, 1'b0);
        drain();
        chk("miss2a_lock", lock, 1);
        feed(seq_b, 0, 62, 1'b0);
        drain();
        chk("miss2_pre_lock", lock, 1);
        feed(seq_b, 62, 1, 1'b0);
        drain();
        chk("miss2b_lock", lock, 0);

        clr();
        load_seed(6'h15, 1'b0, low);
        feed(seq_a, 0, 63, 1'b1);
        drain();
        chk("inv_corr1", last_corr, -63);
        feed(seq_a, 0, 63, 1'b1);
        drain();
        chk("inv_corr2", last_corr, -63);
        chk("inv_neg_count", nneg, 2);
        chk("inv_peaks", npk, 0);
        chk("inv_lock", lock, 0);

        // seed transfer collides with a valid chip while locked
        clr();
        load_seed(6'h15, 1'b0, low);
        feed(seq_a, 0, 126, 1'b0);
        drain();
        chk("relock", lock, 1);
        nres = 0;
        code2 = 6'h15;
        tvalid = 1'b1;
        chip = seq_a[0];
        chip_valid = 1'b1;
        cycle();
        tvalid = 1'b0;
        chip_valid = 1'b0;
        chk("xfer_lock", lock, 0);
        chk("xfer_ready", ready, 0);
        repeat (4) cycle();
        chk("xfer_drop", nres, 0);
        wait_ready();

        clr();
        load_seed(6'h00, 1'b0, low);
        chk("zero_ready_low", low, 63);
        feed(seq_c, 0, 63, 1'b0);
        drain();
        chk("zero_corr", last_corr, 63);
        chk("zero_peaks", npk, 1);

        // asynchronous reset in the middle of generation
        clr();
        code2 = 6'h15;
        tvalid = 1'b1;
        cycle();
        tvalid = 1'b0;
        repeat (20) cycle();
        chk("midgen_ready", ready, 0);
        rstn = 1'b0;
        #2;
        chk("rst2_ready", ready, 1);
        chk("rst2_corr", int'(corr), 0);
        chk("rst2_valid", corr_valid, 0);
        chk("rst2_peak", peak, 0);
        chk("rst2_phase", phase, 0);
        chk("rst2_lock", lock, 0);
        cycle();
        rstn = 1'b1;
        feed(seq_a, 0, 70, 1'b0);
        drain();
        chk("post_rst_drop", nres, 0);
        load_seed(6'h15, 1'b0, low);
        chk("reseed_ready_low", low, 63);
        feed(seq_a, 0, 63, 1'b0);
        drain();
        chk("reseed_corr", last_corr, 63);
        chk("reseed_results", nres, 63);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
